// File: rtl/fifo_queue_if.sv
// rtl/fifo_queue_if.sv - push/pop request and status bundle for fifo_queue
// The producer/consumer side drives the master modport; the queue is the slave.
interface fifo_queue_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 3
);
   logic              push;
   logic              pop;
   logic [WIDTH-1:0]  data_in;
   logic [WIDTH-1:0]  data_out;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              underflow;

   modport master (
      output push, pop, data_in,
      input  data_out, empty, full, count, overflow, underflow
   );

   modport slave (
      input  push, pop, data_in,
      output data_out, empty, full, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_queue.sv
// rtl/fifo_queue.sv - single-clock byte FIFO with count/full status and sticky errors
// Oldest entry is served first; read data is registered with one cycle of latency.
module fifo_queue #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic           clk,
   input  logic           reset,
   fifo_queue_if.slave    bus
);
   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_empty;
   logic              r_full;
   logic [WIDTH-1:0]  r_data_out;
   logic              r_overflow;
   logic              r_underflow;

   logic              w_pop_ok;
   logic              w_push_ok;
   logic [ADDR_W:0]   w_count_nxt;

   // A pop on a full queue frees the slot, so a same-cycle push is still accepted.
   always_comb begin
      w_pop_ok    = bus.pop && !r_empty;
      w_push_ok   = bus.push && (!r_full || w_pop_ok);
      w_count_nxt = r_count;
      if (w_push_ok && !w_pop_ok) begin
         w_count_nxt = r_count + (ADDR_W+1)'(1);
      end else if (w_pop_ok && !w_push_ok) begin
         w_count_nxt = r_count - (ADDR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_push_ok) begin
         r_mem[r_wr_ptr] <= bus.data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_empty     <= 1'b1;
         r_full      <= 1'b0;
         r_data_out  <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_pop_ok) begin
            r_data_out <= r_mem[r_rd_ptr];
            r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
         end
         // Status comes from the next count so it is exact on the same edge.
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == (ADDR_W+1)'(DEPTH));
         if (bus.push && !w_push_ok) begin
            r_overflow <= 1'b1;
         end
         if (bus.pop && !w_pop_ok) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign bus.data_out  = r_data_out;
   assign bus.empty     = r_empty;
   assign bus.full      = r_full;
   assign bus.count     = r_count;
   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_fifo_queue.sv
// tb/tb_fifo_queue.sv - directed and randomized bench for fifo_queue against a queue model
module tb_fifo_queue;
   localparam int WIDTH  = 8;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fifo_queue_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   fifo_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] m_dout = '0;
   bit               m_ovf  = 1'b0;
   bit               m_unf  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_empty"}, 32'(bus.empty),     32'(q.size() == 0));
      chk({tag, "_full"},  32'(bus.full),      32'(q.size() == DEPTH));
      chk({tag, "_count"}, 32'(bus.count),     32'(q.size()));
      chk({tag, "_dout"},  32'(bus.data_out),  32'(m_dout));
      chk({tag, "_ovf"},   32'(bus.overflow),  32'(m_ovf));
      chk({tag, "_unf"},   32'(bus.underflow), 32'(m_unf));
   endtask

   // Drive one cycle of requests, advance the model, then compare everything.
   task automatic step(input bit p, input bit o, input logic [WIDTH-1:0] d, input string tag);
      bit pop_ok;
      bit push_ok;
      bus.push    = p;
      bus.pop     = o;
      bus.data_in = d;
      @(posedge clk);
      if (reset) begin
         q.delete();
         m_dout = '0;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
      end else begin
         pop_ok  = o && (q.size() > 0);
         push_ok = p && ((q.size() < DEPTH) || pop_ok);
         if (pop_ok)     m_dout = q.pop_front();
         if (push_ok)    q.push_back(d);
         if (p && !push_ok) m_ovf = 1'b1;
         if (o && !pop_ok)  m_unf = 1'b1;
      end
      #1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      check_all(tag);
   endtask

   initial begin
      bus.push    = 1'b0;
      bus.pop     = 1'b0;
      bus.data_in = '0;

      reset = 1'b1;
      step(0, 0, 8'h00, "reset");
      reset = 1'b0;
      step(0, 0, 8'h00, "idle0");
      step(0, 0, 8'h00, "idle1");
      chk("reset_count_const", 32'(bus.count), 32'd0);

      step(1, 0, 8'h11, "push11");
      step(1, 0, 8'h22, "push22");
      step(1, 0, 8'h33, "push33");
      chk("count3_const", 32'(bus.count), 32'd3);
      step(0, 1, 8'h00, "pop1");
      chk("dout11_const", 32'(bus.data_out), 32'h11);
      step(0, 1, 8'h00, "pop2");
      chk("dout22_const", 32'(bus.data_out), 32'h22);
      step(0, 1, 8'h00, "pop3");
      chk("dout33_const", 32'(bus.data_out), 32'h33);
      chk("empty_after3", 32'(bus.empty), 32'd1);

      for (int i = 0; i < 8; i++) step(1, 0, 8'(i), "fill");
      chk("full_const", 32'(bus.full), 32'd1);
      step(1, 0, 8'hFF, "push_on_full");
      chk("ovf_const", 32'(bus.overflow), 32'd1);
      chk("count8_const", 32'(bus.count), 32'd8);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 8'h00, "drain");
         chk("drain_order", 32'(bus.data_out), 32'(i));
      end

      for (int i = 0; i < 8; i++) step(1, 0, 8'(i), "refill");
      step(1, 1, 8'hAA, "full_push_pop");
      chk("full_pp_dout", 32'(bus.data_out), 32'h00);
      chk("full_pp_count", 32'(bus.count), 32'd8);
      for (int i = 1; i < 9; i++) step(0, 1, 8'h00, "wrap_drain");
      chk("wrap_last_aa", 32'(bus.data_out), 32'hAA);

      step(0, 1, 8'h00, "pop_empty");
      chk("unf_const", 32'(bus.underflow), 32'd1);
      chk("unf_dout_hold", 32'(bus.data_out), 32'hAA);
      step(1, 1, 8'h5A, "empty_push_pop");
      chk("epp_count", 32'(bus.count), 32'd1);
      step(0, 1, 8'h00, "pop_5a");
      chk("dout5a_const", 32'(bus.data_out), 32'h5A);

      for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h40 + i), "pre_reset");
      reset = 1'b1;
      step(1, 0, 8'h77, "reset_mid");
      reset = 1'b0;
      chk("rst_mid_ovf", 32'(bus.overflow), 32'd0);
      step(0, 1, 8'h00, "pop_after_reset");
      chk("rst_mid_unf", 32'(bus.underflow), 32'd1);

      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         step(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 45),
              8'($urandom), "rand");
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
